// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the index decoder scoreboard.
//
// N      - number of pending-bitmap entries (2..16)
// IDX_W  - width of an entry index
// CNT_W  - width of a population count covering 0..N
//
// The optional duplicate-operation checker in the top module is enabled
// by defining SCOREBOARD_DUP_CHK_EN.
package scoreboard_pkg;

    localparam int N     = 16;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    typedef logic [N-1:0]     bitmap_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/index_decoder.sv
// Combinational index-to-one-hot decoder.
//
// Ports:
//   idx    - index to decode
//   valid  - request qualifier; low forces an all-zero output
//   onehot - 1 << idx when valid and idx < N, otherwise all zeros
//
// Indices at or beyond N decode to zero, so an out-of-range request
// behaves exactly like no request at all.
module index_decoder #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             valid,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = valid && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/index_decoder_scoreboard.sv
// Pending-request scoreboard: decodes set/clear index requests into a
// registered N-bit pending bitmap that feeds a priority encoder.
//
// Ports:
//   clk_i        - clock, all state updates on the rising edge
//   rst_i        - synchronous active-high reset, overrides any request
//   set_valid_i  - set request qualifier
//   set_idx_i    - index of the bit to set
//   clr_valid_i  - clear request qualifier
//   clr_idx_i    - index of the bit to clear
//   onehot_o     - one-cycle registered decode of the last accepted set
//   bitmap_o     - registered pending bitmap
//   count_o      - number of bits set in bitmap_o
//   empty_o      - bitmap_o is all zeros
//   full_o       - bitmap_o is all ones
//   err_o        - duplicate-operation pulse (only with the checker)
//
// Build option: define SCOREBOARD_DUP_CHK_EN to enable the duplicate
// set/clear checker driving err_o. When undefined err_o is tied low.
module index_decoder_scoreboard #(
    parameter int N     = scoreboard_pkg::N,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_valid_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic             clr_valid_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    output logic [N-1:0]     onehot_o,
    output logic [N-1:0]     bitmap_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             err_o
);

    logic [N-1:0]     dec_set;
    logic [N-1:0]     dec_clr;
    logic [N-1:0]     bitmap_q;
    logic [N-1:0]     bitmap_next;
    logic [N-1:0]     onehot_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             empty_q;
    logic             full_q;

    index_decoder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_set_dec (
        .idx    (set_idx_i),
        .valid  (set_valid_i),
        .onehot (dec_set)
    );

    index_decoder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_clr_dec (
        .idx    (clr_idx_i),
        .valid  (clr_valid_i),
        .onehot (dec_clr)
    );

    // Clear is applied first so a same-index set+clear leaves the bit set.
    assign bitmap_next = (bitmap_q & ~dec_clr) | dec_set;

    // Count is taken from the next bitmap so it stays exact when a set and
    // a clear land in the same cycle.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < N; i++) begin
            count_next = count_next + CNT_W'(bitmap_next[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bitmap_q <= '0;
            onehot_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            bitmap_q <= bitmap_next;
            onehot_q <= dec_set;
            count_q  <= count_next;
            empty_q  <= (bitmap_next == '0);
            full_q   <= (bitmap_next == '1);
        end
    end

`ifdef SCOREBOARD_DUP_CHK_EN
    logic set_dup;
    logic clr_dup;
    logic err_q;

    // Judged against the bitmap before update. A clear paired with a set of
    // the same index is never a duplicate by itself; only the set can be.
    assign set_dup = |(dec_set & bitmap_q);
    assign clr_dup = |(dec_clr & ~bitmap_q & ~dec_set);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= set_dup | clr_dup;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bitmap_o = bitmap_q;
    assign onehot_o = onehot_q;
    assign count_o  = count_q;
    assign empty_o  = empty_q;
    assign full_o   = full_q;

endmodule

// File: tb/tb_index_decoder_scoreboard.sv
// Self-checking bench for index_decoder_scoreboard (N = 16).
// Table-driven cycle vectors followed by set-all / clear-all and
// reset-during-activity sequences. err_o expectations follow the
// SCOREBOARD_DUP_CHK_EN build option.
module tb_index_decoder_scoreboard;
    import scoreboard_pkg::*;

`ifdef SCOREBOARD_DUP_CHK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        set_valid_i = 1'b0;
    logic [3:0]  set_idx_i = '0;
    logic        clr_valid_i = 1'b0;
    logic [3:0]  clr_idx_i = '0;
    logic [15:0] onehot_o;
    logic [15:0] bitmap_o;
    logic [4:0]  count_o;
    logic        empty_o;
    logic        full_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    index_decoder_scoreboard dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_valid_i (set_valid_i),
        .set_idx_i   (set_idx_i),
        .clr_valid_i (clr_valid_i),
        .clr_idx_i   (clr_idx_i),
        .onehot_o    (onehot_o),
        .bitmap_o    (bitmap_o),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        sv;
        logic [3:0]  si;
        logic        cv;
        logic [3:0]  ci;
        logic [15:0] bm;
        logic [15:0] oh;
        logic [4:0]  cnt;
        logic        em;
        logic        fu;
        logic        dup;
        int          top;   // expected priority-encoder index, -1 = none
    } vec_t;

    vec_t vecs[$];

    // Reference 16-input priority encoder: highest set index, -1 if none.
    function automatic int prio_of(input logic [15:0] b);
        int r = -1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) r = i;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic sv, input logic [3:0] si,
                       input logic cv, input logic [3:0] ci,
                       input logic [15:0] bm, input logic [15:0] oh,
                       input logic [4:0] cnt, input logic em, input logic fu,
                       input logic dup, input int top);
        vec_t v;
        v.rst = rst; v.sv = sv; v.si = si; v.cv = cv; v.ci = ci;
        v.bm = bm; v.oh = oh; v.cnt = cnt; v.em = em; v.fu = fu;
        v.dup = dup; v.top = top;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic sv, input logic [3:0] si,
                         input logic cv, input logic [3:0] ci);
        rst_i = rst; set_valid_i = sv; set_idx_i = si;
        clr_valid_i = cv; clr_idx_i = ci;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //   rst sv  si  cv  ci   bitmap    onehot    cnt em fu dup top
        add(1, 0, 0,  0, 0,  16'h0000, 16'h0000, 0, 1, 0, 0, -1);
        add(0, 1, 5,  0, 0,  16'h0020, 16'h0020, 1, 0, 0, 0,  5);
        add(0, 0, 0,  0, 0,  16'h0020, 16'h0000, 1, 0, 0, 0,  5);
        add(1, 0, 0,  0, 0,  16'h0000, 16'h0000, 0, 1, 0, 0, -1);
        add(0, 1, 0,  0, 0,  16'h0001, 16'h0001, 1, 0, 0, 0,  0);
        add(0, 1, 3,  0, 0,  16'h0009, 16'h0008, 2, 0, 0, 0,  3);
        add(0, 1, 15, 0, 0,  16'h8009, 16'h8000, 3, 0, 0, 0, 15);
        add(0, 0, 0,  1, 3,  16'h8001, 16'h0000, 2, 0, 0, 0, 15);
        add(1, 0, 0,  0, 0,  16'h0000, 16'h0000, 0, 1, 0, 0, -1);
        add(0, 1, 7,  1, 7,  16'h0080, 16'h0080, 1, 0, 0, 0,  7);
        add(0, 1, 2,  1, 7,  16'h0004, 16'h0004, 1, 0, 0, 0,  2);
        add(0, 1, 9,  0, 0,  16'h0204, 16'h0200, 2, 0, 0, 0,  9);
        add(0, 1, 9,  0, 0,  16'h0204, 16'h0200, 2, 0, 0, 1,  9);
        add(0, 0, 0,  0, 0,  16'h0204, 16'h0000, 2, 0, 0, 0,  9);
        add(1, 0, 0,  0, 0,  16'h0000, 16'h0000, 0, 1, 0, 0, -1);
        add(0, 0, 0,  1, 1,  16'h0000, 16'h0000, 0, 1, 0, 1, -1);
        add(0, 1, 4,  0, 0,  16'h0010, 16'h0010, 1, 0, 0, 0,  4);
        add(0, 1, 4,  1, 4,  16'h0010, 16'h0010, 1, 0, 0, 1,  4);
        add(0, 0, 0,  1, 2,  16'h0010, 16'h0000, 1, 0, 0, 1,  4);
        add(0, 0, 0,  0, 0,  16'h0010, 16'h0000, 1, 0, 0, 0,  4);

        @(posedge clk_i);
        #1;
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].sv, vecs[k].si, vecs[k].cv, vecs[k].ci);
            check($sformatf("row%0d bitmap", k), 32'(bitmap_o), 32'(vecs[k].bm));
            check($sformatf("row%0d onehot", k), 32'(onehot_o), 32'(vecs[k].oh));
            check($sformatf("row%0d count",  k), 32'(count_o),  32'(vecs[k].cnt));
            check($sformatf("row%0d empty",  k), 32'(empty_o),  32'(vecs[k].em));
            check($sformatf("row%0d full",   k), 32'(full_o),   32'(vecs[k].fu));
            check($sformatf("row%0d err",    k), 32'(err_o),    32'(DUP_EN & vecs[k].dup));
            check($sformatf("row%0d prio",   k), 32'(prio_of(bitmap_o)), 32'(vecs[k].top));
        end

        // Fill every entry from empty, one per cycle.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 4'(i), 0, 0);
            check($sformatf("fill%0d count", i), 32'(count_o), 32'(i + 1));
            check($sformatf("fill%0d onehot", i), 32'(onehot_o), 32'(1) << i);
            check($sformatf("fill%0d full", i), 32'(full_o), 32'(i == 15));
            check($sformatf("fill%0d empty", i), 32'(empty_o), 32'(0));
        end
        check("fill bitmap", 32'(bitmap_o), 32'h0000_FFFF);

        // Drain every entry, one per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 4'(i));
            check($sformatf("drain%0d count", i), 32'(count_o), 32'(15 - i));
            check($sformatf("drain%0d empty", i), 32'(empty_o), 32'(i == 15));
            check($sformatf("drain%0d full", i), 32'(full_o), 32'(0));
            check($sformatf("drain%0d err", i), 32'(err_o), 32'(0));
        end
        check("drain bitmap", 32'(bitmap_o), 32'h0);

        // Refill, then reset together with a set: reset must win.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 4'(i), 0, 0);
        end
        check("refill full", 32'(full_o), 32'(1));
        drive(1, 1, 4, 0, 0);
        check("rst bitmap", 32'(bitmap_o), 32'h0);
        check("rst onehot", 32'(onehot_o), 32'h0);
        check("rst count",  32'(count_o),  32'h0);
        check("rst empty",  32'(empty_o),  32'h1);
        check("rst full",   32'(full_o),   32'h0);
        check("rst err",    32'(err_o),    32'h0);
        drive(0, 0, 0, 0, 0);
        check("post-rst onehot", 32'(onehot_o), 32'h0);
        check("post-rst bitmap", 32'(bitmap_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
